// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full-adder cell is stepped over WIDTH cycles,
// LSB first, with a carry flop between bits and a start/busy/done handshake.

module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, a_sh_next;
  logic [WIDTH-1:0] b_sh_reg, b_sh_next;
  logic [WIDTH-1:0] s_sh_reg, s_sh_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             carry_reg, carry_next;
  logic             cout_reg, cout_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             fa_sum, fa_cout;
  logic [WIDTH-1:0] s_shifted;

  full_adder u_fa (
    .x  (a_sh_reg[0]),
    .y  (b_sh_reg[0]),
    .ci (carry_reg),
    .s  (fa_sum),
    .co (fa_cout)
  );

  // New sum bit enters at the MSB; a single-bit build has nothing to shift in behind it.
  generate
    if (WIDTH == 1) begin : g_w1
      assign s_shifted = fa_sum;
    end else begin : g_wn
      assign s_shifted = {fa_sum, s_sh_reg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      s_sh_reg  <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      a_sh_reg  <= a_sh_next;
      b_sh_reg  <= b_sh_next;
      s_sh_reg  <= s_sh_next;
      sum_reg   <= sum_next;
      carry_reg <= carry_next;
      cout_reg  <= cout_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_sh_next  = a_sh_reg;
    b_sh_next  = b_sh_reg;
    s_sh_next  = s_sh_reg;
    sum_next   = sum_reg;
    carry_next = carry_reg;
    cout_next  = cout_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          a_sh_next  = a;
          b_sh_next  = b;
          carry_next = cin;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        s_sh_next  = s_shifted;
        a_sh_next  = a_sh_reg >> 1;
        b_sh_next  = b_sh_reg >> 1;
        carry_next = fa_cout;
        cnt_next   = cnt_reg + CW'(1);
        // Result registers change only here, so no partial sum is ever visible.
        if (cnt_reg == LAST_CNT) begin
          sum_next   = s_shifted;
          cout_next  = fa_cout;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: vector table at WIDTH=8, hand sequences
// for held start and mid-run reset, and exhaustive sweeps on WIDTH=1 and WIDTH=4.

module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  // WIDTH=1 instance
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;
  // WIDTH=4 instance
  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );
  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );
  serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One WIDTH=8 add; operands are scrambled right after acceptance so any
  // late sampling of a/b/cin would corrupt the result.
  task automatic do_add8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                         input logic [7:0] prev_sum, input logic prev_cout,
                         output logic [7:0] rs, output logic rc,
                         output int lat, output int busy_cnt, output logic hold_ok);
    a8 = ta; b8 = tb_v; cin8 = tc; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    lat = 1; busy_cnt = 0; hold_ok = 1'b1;
    while (!done8 && lat < 40) begin
      if (busy8) busy_cnt++;
      if (sum8 !== prev_sum || cout8 !== prev_cout) hold_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (busy8 && done8) hold_ok = 1'b0;
    rs = sum8; rc = cout8;
    @(posedge clk); #1;
    if (done8 || busy8) hold_ok = 1'b0;
  endtask

  task automatic sweep_add(input int w, input int ta, input int tb_v, input int tc,
                           output int res, output int lat);
    if (w == 1) begin
      a1 = 1'(ta); b1 = 1'(tb_v); cin1 = 1'(tc); start1 = 1'b1;
    end else begin
      a4 = 4'(ta); b4 = 4'(tb_v); cin4 = 1'(tc); start4 = 1'b1;
    end
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0;
    lat = 1;
    while (!((w == 1) ? done1 : done4) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = (w == 1) ? int'({cout1, sum1}) : int'({cout4, sum4});
    @(posedge clk); #1;
  endtask

  vec_t       vecs [9];
  logic [7:0] rs, prev_s;
  logic       rc, prev_c, hold_ok, seq_ok;
  int         lat, bcnt, ndone, res;

  initial begin
    vecs[0] = '{a: 8'h03, b: 8'h05, cin: 1'b0, sum: 8'h08, cout: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1};
    vecs[2] = '{a: 8'hAA, b: 8'h55, cin: 1'b1, sum: 8'h00, cout: 1'b1};
    vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b0, sum: 8'h00, cout: 1'b0};
    vecs[4] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1};
    vecs[5] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1};
    vecs[6] = '{a: 8'h12, b: 8'h34, cin: 1'b1, sum: 8'h47, cout: 1'b0};
    vecs[7] = '{a: 8'h7F, b: 8'h00, cin: 1'b1, sum: 8'h80, cout: 1'b0};
    vecs[8] = '{a: 8'hF0, b: 8'h0F, cin: 1'b0, sum: 8'hFF, cout: 1'b0};

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy8, 0);
    chk("reset_done", done8, 0);
    chk("reset_sum", sum8, 0);
    chk("reset_cout", cout8, 0);
    $display("[TB] reset: busy=%0b done=%0b sum=%02h cout=%0b", busy8, done8, sum8, cout8);
    rst_n = 1'b1;
    @(posedge clk); #1;

    prev_s = 8'h00; prev_c = 1'b0;
    for (int i = 0; i < 9; i++) begin
      do_add8(vecs[i].a, vecs[i].b, vecs[i].cin, prev_s, prev_c, rs, rc, lat, bcnt, hold_ok);
      $display("[TB] vec%0d: %02h+%02h+%0b -> sum=%02h cout=%0b lat=%0d busy=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, lat, bcnt);
      chk($sformatf("vec%0d_sum", i), rs, vecs[i].sum);
      chk($sformatf("vec%0d_cout", i), rc, vecs[i].cout);
      chk($sformatf("vec%0d_latency", i), lat, 9);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, 8);
      chk($sformatf("vec%0d_hold", i), hold_ok, 1);
      prev_s = vecs[i].sum; prev_c = vecs[i].cout;
    end

    // start held high: a new add every WIDTH+2 cycles, result held in between
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    ndone = 0; seq_ok = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (busy8 && done8) seq_ok = 1'b0;
      if (done8) begin
        ndone++;
        $display("[TB] held start: done at cycle %0d sum=%02h cout=%0b", k, sum8, cout8);
        if (k != 9 + 10 * (ndone - 1)) seq_ok = 1'b0;
        if (sum8 !== 8'h02 || cout8 !== 1'b0) seq_ok = 1'b0;
      end else if (sum8 !== ((ndone == 0) ? 8'hFF : 8'h02)) begin
        seq_ok = 1'b0;
      end
    end
    start8 = 1'b0;
    chk("held_start_done_count", ndone, 3);
    chk("held_start_timing", seq_ok, 1);

    // reset in the fourth RUN cycle aborts the add
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_abort_busy", busy8, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("[TB] abort: busy=%0b done=%0b sum=%02h cout=%0b", busy8, done8, sum8, cout8);
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_sum", sum8, 0);
    chk("abort_cout", cout8, 0);
    ndone = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done8 || busy8) ndone++;
    end
    chk("abort_no_activity", ndone, 0);
    do_add8(8'h12, 8'h34, 1'b1, 8'h00, 1'b0, rs, rc, lat, bcnt, hold_ok);
    $display("[TB] after abort: 12+34+1 -> sum=%02h cout=%0b lat=%0d", rs, rc, lat);
    chk("after_abort_sum", {rc, rs}, 9'h047);
    chk("after_abort_latency", lat, 9);
    chk("after_abort_hold", hold_ok, 1);

    // exhaustive sweeps on the narrow builds
    for (int w = 1; w <= 4; w += 3) begin
      for (int x = 0; x < (1 << w); x++) begin
        for (int y = 0; y < (1 << w); y++) begin
          for (int c = 0; c < 2; c++) begin
            sweep_add(w, x, y, c, res, lat);
            $display("[TB] w%0d: %0d+%0d+%0d -> %0d lat=%0d", w, x, y, c, res, lat);
            chk($sformatf("w%0d_%0d_%0d_%0d_result", w, x, y, c), res, x + y + c);
            chk($sformatf("w%0d_%0d_%0d_%0d_latency", w, x, y, c), lat, w + 1);
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
